dmem_uart_bridge: RTL and testbench

//   Data-side memory stage for the single-cycle MIPS core: consumes memwrite/aluout/writedata, returns readdata.

---
 rtl/dmem_uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/dmem_uart_bridge.sv | 180 ++++++++++++++++++
 tb/tb_dmem_uart_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_uart_pkg.sv
// rtl/dmem_uart_pkg.sv - MMIO offsets, STATUS bit positions and TX FSM states for dmem_uart_bridge
package dmem_uart_pkg;

    localparam logic [1:0] MMIO_TXDATA = 2'd0;
    localparam logic [1:0] MMIO_STATUS = 2'd1;
    localparam logic [1:0] MMIO_CYCLES = 2'd2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with first-word-fall-through read port
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dmem_uart_bridge.sv
// rtl/dmem_uart_bridge.sv - data RAM plus memory-mapped UART TX; DMEM_UART_CYCLE_COUNTER_EN adds the CYCLES counter
module dmem_uart_bridge
    import dmem_uart_pkg::*;
#(
    parameter int DMEM_WORDS   = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        uart_tx
);
    localparam int RAM_AW = $clog2(DMEM_WORDS);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram_q [DMEM_WORDS];
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio_sel;
    logic [1:0]        mmio_off;
    logic              txdata_wr, status_wr, push_drop;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [7:0]        fifo_data;
    logic [CNT_W-1:0]  fifo_count;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              baud_last;
    logic [31:0]       cycles_val;
    logic              unused_bits;

    assign ram_idx     = aluout[RAM_AW+1:2];
    assign mmio_sel    = aluout[31];
    assign mmio_off    = aluout[3:2];
    assign txdata_wr   = memwrite && mmio_sel && (mmio_off == MMIO_TXDATA);
    assign status_wr   = memwrite && mmio_sel && (mmio_off == MMIO_STATUS);
    assign push_drop   = txdata_wr && fifo_full && !fifo_pop;
    assign baud_last   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign uart_tx     = tx_q;
    assign unused_bits = ^{aluout[30:RAM_AW+2], aluout[1:0], writedata[31:8]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (txdata_wr),
        .push_data (writedata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (memwrite && !mmio_sel) begin
            ram_q[ram_idx] <= writedata;
        end
    end

`ifdef DMEM_UART_CYCLE_COUNTER_EN
    logic [31:0] cycles_q, cycles_d;

    always_comb cycles_d = cycles_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

    assign cycles_val = cycles_q;
`else
    assign cycles_val = '0;
`endif

    always_comb begin
        readdata = '0;
        if (!mmio_sel) begin
            readdata = ram_q[ram_idx];
        end else begin
            case (mmio_off)
                MMIO_STATUS: begin
                    readdata[STAT_COUNT_LSB +: 4] = 4'(fifo_count);
                    readdata[STAT_OVF]            = ovf_q;
                    readdata[STAT_EMPTY]          = fifo_empty;
                    readdata[STAT_FULL]           = fifo_full;
                    readdata[STAT_BUSY]           = (state_q != ST_IDLE);
                end
                MMIO_CYCLES: readdata = cycles_val;
                default:     readdata = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        ovf_d     = ovf_q;

        if (status_wr && writedata[STAT_OVF]) ovf_d = 1'b0;
        if (push_drop)                        ovf_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    baud_d   = '0;
                    tx_d     = 1'b0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_dmem_uart_bridge.sv
// tb/tb_dmem_uart_bridge.sv - scoreboard bench for dmem_uart_bridge (loads and serial frames)
module tb_dmem_uart_bridge;
    localparam int CPB = 4;
    localparam logic [31:0] A_TXDATA = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLES = 32'h8000_0008;
    localparam logic [31:0] A_RSVD   = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] aluout = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        uart_tx;

    int checks = 0;
    int failures = 0;

    logic        rd_strobe = 1'b0;
    logic [63:0] rd_q[$];
    string       name_q[$];
    logic [7:0]  tx_exp[$];
    logic [63:0] rd_e;
    string       rd_n;

    always #5 clk = ~clk;

    dmem_uart_bridge #(
        .DMEM_WORDS   (64),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .uart_tx   (uart_tx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Load monitor: compares readdata mid-cycle whenever a load is presented.
    always @(negedge clk) begin
        if (rd_strobe) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_scoreboard_empty: got 0x%08h expected none", readdata);
            end else begin
                rd_e = rd_q.pop_front();
                rd_n = name_q.pop_front();
                check(rd_n, readdata & rd_e[63:32], rd_e[31:0]);
            end
        end
    end

    // Serial monitor: decodes each frame cycle by cycle; a reset abandons the frame.
    initial begin
        logic       ok, aborted;
        logic [7:0] rx;
        logic [7:0] e;
        int         b;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && uart_tx === 1'b0) begin
                ok = 1'b1;
                aborted = 1'b0;
                rx = '0;
                for (int c = 0; c < 10 * CPB; c++) begin
                    if (c > 0) @(negedge clk);
                    if (reset !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    b = c / CPB;
                    if (b == 0) begin
                        if (uart_tx !== 1'b0) ok = 1'b0;
                    end else if (b == 9) begin
                        if (uart_tx !== 1'b1) ok = 1'b0;
                    end else if (c % CPB == 0) begin
                        rx[b-1] = uart_tx;
                    end else if (uart_tx !== rx[b-1]) begin
                        ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    if (tx_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL uart_unexpected_frame: got 0x%02h expected no frame", rx);
                    end else begin
                        e = tx_exp.pop_front();
                        check("uart_frame_shape", {31'b0, ok}, 32'd1);
                        check("uart_byte", {24'b0, rx}, {24'b0, e});
                    end
                end
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        aluout = a;
        writedata = d;
        memwrite = 1'b1;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
    endtask

    task automatic load(input string n, input logic [31:0] a, input logic [31:0] exp,
                        input logic [31:0] mask = 32'hFFFF_FFFF);
        aluout = a;
        memwrite = 1'b0;
        rd_q.push_back({mask, exp & mask});
        name_q.push_back(n);
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic store_rd(input string n, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp);
        rd_q.push_back({32'hFFFF_FFFF, exp});
        name_q.push_back(n);
        rd_strobe = 1'b1;
        store(a, d);
        rd_strobe = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] d, input bit accepted);
        if (accepted) tx_exp.push_back(d);
        store(A_TXDATA, {24'b0, d});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx_exp.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_tx_done(input string n, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (tx_exp.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(n, 32'(tx_exp.size()), 32'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic low_seen;

        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        @(posedge clk);
        #1;
        load("rst_status", A_STATUS, 32'h04);

        // RAM, aliasing, ignored byte offset, read-during-write
        store(32'h10, 32'h1234_5678);
        load("ram_rd", 32'h10, 32'h1234_5678);
        load("ram_alias", 32'h110, 32'h1234_5678);
        load("ram_byteoff", 32'h13, 32'h1234_5678);
        store_rd("ram_rdw_old", 32'h10, 32'hDEAD_BEEF, 32'h1234_5678);
        load("ram_rd_new", 32'h10, 32'hDEAD_BEEF);
        store(32'hFC, 32'hA5A5_A5A5);
        load("ram_top_alias", 32'h1FC, 32'hA5A5_A5A5);
        load("ram_other_word", 32'h10, 32'hDEAD_BEEF);

        load("mmio_rsvd", A_RSVD, 32'h0);
        load("mmio_txdata_rd", A_TXDATA, 32'h0);

        // Single byte: latency and busy throughout the frame
        tx_byte(8'h55, 1'b1);
        @(negedge clk);
        check("tx_idle_before_e1", {31'b0, uart_tx}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("tx_start_at_e1", {31'b0, uart_tx}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            load("status_busy", A_STATUS, 32'h05);
            repeat (3) begin
                @(posedge clk);
                #1;
            end
        end
        wait_tx_done("single_done", 200);
        load("status_after_single", A_STATUS, 32'h04);

        // Overflow: one in the shifter, four queued, the sixth dropped
        for (int i = 1; i <= 6; i++) tx_byte(8'(i), i <= 5);
        load("status_ovf_fields", A_STATUS, 32'h4A, 32'hFFFF_FFFE);
        load("status_ovf_busy", A_STATUS, 32'h01, 32'h0000_0001);
        store(A_STATUS, 32'h8);
        load("status_ovf_cleared", A_STATUS, 32'h43);
        wait_tx_done("ovf_frames_done", 400);
        load("status_after_ovf", A_STATUS, 32'h04);

        // Reset during DATA bit 3 of 0xA5 with two more bytes queued
        tx_byte(8'hA5, 1'b1);
        tx_byte(8'h3C, 1'b1);
        tx_byte(8'h96, 1'b1);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("mid_frame_bit3", {31'b0, uart_tx}, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        check("tx_high_after_reset", {31'b0, uart_tx}, 32'd1);
        load("status_after_reset", A_STATUS, 32'h04);
        low_seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low_seen = 1'b1;
        end
        check("no_frames_after_reset", {31'b0, low_seen}, 32'd0);
        @(posedge clk);
        #1;

        // Cycle counter and ignored CYCLES writes
        do_reset();
        repeat (100) begin
            @(posedge clk);
            #1;
        end
`ifdef DMEM_UART_CYCLE_COUNTER_EN
        load("cycles_100", A_CYCLES, 32'd100);
        store(A_CYCLES, 32'h0);
        load("cycles_write_ignored", A_CYCLES, 32'd102);
`else
        load("cycles_100", A_CYCLES, 32'd0);
        store(A_CYCLES, 32'h0);
        load("cycles_write_ignored", A_CYCLES, 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
